hough_peak_finder: RTL and testbench

HOUGH_PEAK_FINDER -- requirements
Module: hough_peak_finder

---
 rtl/hough_peak_finder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_hough_peak_finder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hough_peak_finder.sv
// hough_peak_finder
// Walks a Hough accumulator held in a synchronous-read memory, one address per
// cycle, and reports the strongest (rho, theta) cell in the left half
// (theta < THETAS/2) and in the right half of the theta range. A threshold flag
// says whether each peak holds enough votes to count as a line. The result is
// held with a valid/ready handshake until the consumer takes it.
module hough_peak_finder #(
  parameter int RHO_RANGE   = 1600,
  parameter int THETAS      = 180,
  parameter int ACCUM_WIDTH = 16,
  parameter int THRESHOLD   = 100,
  localparam int N  = RHO_RANGE * THETAS,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (RHO_RANGE > 1) ? $clog2(RHO_RANGE) : 1,
  localparam int TW = (THETAS > 1) ? $clog2(THETAS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic [AW-1:0]          accum_rd_addr,
  input  logic [ACCUM_WIDTH-1:0] accum_rd_data,
  output logic [RW-1:0]          left_rho,
  output logic [TW-1:0]          left_theta,
  output logic                   left_valid,
  output logic [RW-1:0]          right_rho,
  output logic [TW-1:0]          right_theta,
  output logic                   right_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0]          ADDR_LAST  = AW'(N - 1);
  localparam logic [TW-1:0]          THETA_LAST = TW'(THETAS - 1);
  localparam logic [TW-1:0]          THETA_HALF = TW'(THETAS / 2);
  localparam logic [ACCUM_WIDTH-1:0] THRESH     = ACCUM_WIDTH'(THRESHOLD);

  state_t state_q, state_d;

  // Address generator: flat address plus separate rho/theta counters so no
  // divider is needed to recover the cell coordinates.
  logic [AW-1:0] addr_q, addr_d;
  logic [RW-1:0] rho_q, rho_d;
  logic [TW-1:0] theta_q, theta_d;

  // Coordinates of the address issued last cycle; they line up with
  // accum_rd_data because the memory has one cycle of read latency.
  logic          trk_vld_q, trk_vld_d;
  logic [RW-1:0] trk_rho_q, trk_rho_d;
  logic [TW-1:0] trk_theta_q, trk_theta_d;

  // Running peaks for each half.
  logic [ACCUM_WIDTH-1:0] left_max_q, left_max_d;
  logic [ACCUM_WIDTH-1:0] right_max_q, right_max_d;
  logic [RW-1:0]          left_rho_q, left_rho_d;
  logic [TW-1:0]          left_theta_q, left_theta_d;
  logic [RW-1:0]          right_rho_q, right_rho_d;
  logic [TW-1:0]          right_theta_q, right_theta_d;
  logic                   left_valid_q, left_valid_d;
  logic                   right_valid_q, right_valid_d;

  // Control strobes decoded from the state.
  logic clr;       // start accepted in IDLE: clear peaks and counters
  logic scan_en;   // an address is being issued this cycle
  logic finish;    // last compare happens this cycle, result latched at the edge
  logic left_upd;
  logic right_upd;
  logic last_addr;

  assign last_addr = (addr_q == ADDR_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE, out_ready only in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = SCAN;
      SCAN:    if (last_addr) state_d = DRAIN;
      DRAIN:                  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // State-decoded outputs and internal strobes.
  always_comb begin
    clr       = 1'b0;
    scan_en   = 1'b0;
    finish    = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        clr  = start;
      end
      SCAN:    scan_en   = 1'b1;
      DRAIN:   finish    = 1'b1;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Address walk: rho-major, theta wraps and carries into rho; returns to 0
  // after the last address so IDLE always presents address 0.
  always_comb begin
    addr_d  = addr_q;
    rho_d   = rho_q;
    theta_d = theta_q;
    if (clr) begin
      addr_d  = '0;
      rho_d   = '0;
      theta_d = '0;
    end else if (scan_en) begin
      if (last_addr) begin
        addr_d  = '0;
        rho_d   = '0;
        theta_d = '0;
      end else begin
        addr_d = addr_q + AW'(1);
        if (theta_q == THETA_LAST) begin
          theta_d = '0;
          rho_d   = rho_q + RW'(1);
        end else begin
          theta_d = theta_q + TW'(1);
        end
      end
    end
  end

  // Address counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      rho_q   <= '0;
      theta_q <= '0;
    end else begin
      addr_q  <= addr_d;
      rho_q   <= rho_d;
      theta_q <= theta_d;
    end
  end

  // Delay the issued coordinates by one cycle to meet the read data.
  always_comb begin
    trk_vld_d   = scan_en;
    trk_rho_d   = rho_q;
    trk_theta_d = theta_q;
  end

  // Tracking pipeline registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trk_vld_q   <= 1'b0;
      trk_rho_q   <= '0;
      trk_theta_q <= '0;
    end else begin
      trk_vld_q   <= trk_vld_d;
      trk_rho_q   <= trk_rho_d;
      trk_theta_q <= trk_theta_d;
    end
  end

  // Peak compare: strictly-greater keeps the lowest address on ties.
  always_comb begin
    left_upd  = trk_vld_q && (trk_theta_q <  THETA_HALF) && (accum_rd_data > left_max_q);
    right_upd = trk_vld_q && (trk_theta_q >= THETA_HALF) && (accum_rd_data > right_max_q);

    left_max_d    = left_max_q;
    left_rho_d    = left_rho_q;
    left_theta_d  = left_theta_q;
    right_max_d   = right_max_q;
    right_rho_d   = right_rho_q;
    right_theta_d = right_theta_q;

    if (clr) begin
      left_max_d    = '0;
      left_rho_d    = '0;
      left_theta_d  = '0;
      right_max_d   = '0;
      right_rho_d   = '0;
      right_theta_d = '0;
    end else begin
      if (left_upd) begin
        left_max_d   = accum_rd_data;
        left_rho_d   = trk_rho_q;
        left_theta_d = trk_theta_q;
      end
      if (right_upd) begin
        right_max_d   = accum_rd_data;
        right_rho_d   = trk_rho_q;
        right_theta_d = trk_theta_q;
      end
    end
  end

  // Peak registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      left_max_q    <= '0;
      left_rho_q    <= '0;
      left_theta_q  <= '0;
      right_max_q   <= '0;
      right_rho_q   <= '0;
      right_theta_q <= '0;
    end else begin
      left_max_q    <= left_max_d;
      left_rho_q    <= left_rho_d;
      left_theta_q  <= left_theta_d;
      right_max_q   <= right_max_d;
      right_rho_q   <= right_rho_d;
      right_theta_q <= right_theta_d;
    end
  end

  // Threshold flags use the post-compare max so the DRAIN-cycle data counts.
  always_comb begin
    left_valid_d  = left_valid_q;
    right_valid_d = right_valid_q;
    if (clr) begin
      left_valid_d  = 1'b0;
      right_valid_d = 1'b0;
    end else if (finish) begin
      left_valid_d  = (left_max_d  >= THRESH);
      right_valid_d = (right_max_d >= THRESH);
    end
  end

  // Threshold flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
    end else begin
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
    end
  end

  assign accum_rd_addr = addr_q;
  assign left_rho      = left_rho_q;
  assign left_theta    = left_theta_q;
  assign left_valid    = left_valid_q;
  assign right_rho     = right_rho_q;
  assign right_theta   = right_theta_q;
  assign right_valid   = right_valid_q;

endmodule

// File: tb/tb_hough_peak_finder.sv
// Bench for hough_peak_finder with a 4x4 accumulator and threshold 5.
module tb_hough_peak_finder;

  localparam int RHO_RANGE   = 4;
  localparam int THETAS      = 4;
  localparam int ACCUM_WIDTH = 16;
  localparam int THRESHOLD   = 5;
  localparam int N           = RHO_RANGE * THETAS;

  typedef struct {
    int fill;
    int a0; int v0;
    int a1; int v1;
    int lr; int lt; int lv;
    int rr; int rt; int rv;
  } vec_t;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic                   out_ready = 1'b0;
  logic [3:0]             accum_rd_addr;
  logic [ACCUM_WIDTH-1:0] accum_rd_data;
  logic [1:0]             left_rho, left_theta, right_rho, right_theta;
  logic                   left_valid, right_valid, out_valid, busy;

  logic [ACCUM_WIDTH-1:0] mem [N];
  vec_t                   sb_q [$];
  int                     n_cmp = 0;
  int                     n_fail = 0;

  hough_peak_finder #(
    .RHO_RANGE  (RHO_RANGE),
    .THETAS     (THETAS),
    .ACCUM_WIDTH(ACCUM_WIDTH),
    .THRESHOLD  (THRESHOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .accum_rd_addr(accum_rd_addr),
    .accum_rd_data(accum_rd_data),
    .left_rho     (left_rho),
    .left_theta   (left_theta),
    .left_valid   (left_valid),
    .right_rho    (right_rho),
    .right_theta  (right_theta),
    .right_valid  (right_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Synchronous-read accumulator memory.
  always @(posedge clock) accum_rd_data <= mem[accum_rd_addr];

  task automatic check(input string name, input int act, input int ev);
    n_cmp++;
    if (act != ev) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, ev);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N; i++) mem[i] = 16'(v.fill);
    mem[v.a0] = 16'(v.v0);
    mem[v.a1] = 16'(v.v1);
  endtask

  // Reference: rho-major walk, strict greater-than, threshold on final max.
  function automatic vec_t model();
    vec_t r = '{default: 0};
    int lm = 0;
    int rm = 0;
    for (int a = 0; a < N; a++) begin
      int v  = int'(mem[a]);
      int rh = a / THETAS;
      int th = a % THETAS;
      if (th < THETAS / 2) begin
        if (v > lm) begin lm = v; r.lr = rh; r.lt = th; end
      end else begin
        if (v > rm) begin rm = v; r.rr = rh; r.rt = th; end
      end
    end
    r.lv = (lm >= THRESHOLD) ? 1 : 0;
    r.rv = (rm >= THRESHOLD) ? 1 : 0;
    return r;
  endfunction

  // Pulse start, wait for the result, check latency and pop/compare the scoreboard.
  task automatic start_and_wait(input vec_t e, input string name);
    vec_t ev;
    int   cyc;
    bit   ok;
    sb_q.push_back(e);
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check({name, " busy after start"}, int'(busy), 1);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 40 && !ok) begin
      @(posedge clock);
      #1;
      cyc++;
      if (out_valid) ok = 1'b1;
    end
    ev = sb_q.pop_front();
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s out_valid timeout: got none within 40 cycles, expected at %0d", name, N + 1);
    end else begin
      check({name, " latency"},     cyc, N + 1);
      check({name, " left_rho"},    int'(left_rho),    ev.lr);
      check({name, " left_theta"},  int'(left_theta),  ev.lt);
      check({name, " left_valid"},  int'(left_valid),  ev.lv);
      check({name, " right_rho"},   int'(right_rho),   ev.rr);
      check({name, " right_theta"}, int'(right_theta), ev.rt);
      check({name, " right_valid"}, int'(right_valid), ev.rv);
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clock) out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check({name, " out_valid after ack"}, int'(out_valid), 0);
    check({name, " busy after ack"},      int'(busy),      0);
  endtask

  task automatic watch_idle(input string name, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (busy || out_valid) seen = 1'b1;
    end
    check({name, " stays idle"}, int'(seen), 0);
  endtask

  initial begin
    vec_t tbl [6];
    vec_t e;
    logic [11:0] exp_pack;
    logic [11:0] act_pack;
    bit hit;

    tbl[0] = '{fill:0, a0:9,  v0:7,     a1:15, v1:9,     lr:2, lt:1, lv:1, rr:3, rt:3, rv:1};
    tbl[1] = '{fill:0, a0:0,  v0:6,     a1:13, v1:6,     lr:0, lt:0, lv:1, rr:0, rt:0, rv:0};
    tbl[2] = '{fill:4, a0:0,  v0:4,     a1:0,  v1:4,     lr:0, lt:0, lv:0, rr:0, rt:2, rv:0};
    tbl[3] = '{fill:0, a0:0,  v0:0,     a1:0,  v1:0,     lr:0, lt:0, lv:0, rr:0, rt:0, rv:0};
    tbl[4] = '{fill:0, a0:6,  v0:5,     a1:12, v1:4,     lr:3, lt:0, lv:0, rr:1, rt:2, rv:1};
    tbl[5] = '{fill:0, a0:1,  v0:65535, a1:2,  v1:32768, lr:0, lt:1, lv:1, rr:0, rt:2, rv:1};

    load_vec(tbl[3]);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset busy",        int'(busy),          0);
    check("reset out_valid",   int'(out_valid),     0);
    check("reset addr",        int'(accum_rd_addr), 0);
    check("reset left_valid",  int'(left_valid),    0);
    check("reset right_valid", int'(right_valid),   0);
    @(negedge clock) reset = 1'b1;
    watch_idle("post-reset", 3);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      load_vec(tbl[i]);
      start_and_wait(tbl[i], $sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Random accumulators against the reference walk
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, 9));
      e = model();
      start_and_wait(e, $sformatf("rand%0d", k));
      handshake($sformatf("rand%0d", k));
    end

    // Held result: out_ready low for 10 cycles, start pulses ignored
    load_vec(tbl[0]);
    start_and_wait(tbl[0], "hold");
    exp_pack = {2'(tbl[0].lr), 2'(tbl[0].lt), 1'(tbl[0].lv),
                2'(tbl[0].rr), 2'(tbl[0].rt), 1'(tbl[0].rv), 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock) start = (i % 2 == 0);
      @(posedge clock);
      #1;
      act_pack = {left_rho, left_theta, left_valid, right_rho, right_theta,
                  right_valid, out_valid, busy};
      check($sformatf("hold stable cyc%0d", i), int'(act_pack), int'(exp_pack));
    end
    @(negedge clock) start = 1'b0;
    handshake("hold");
    watch_idle("hold", 5);

    // Reset at address 8 mid-scan
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[5]  = 16'd7;
    mem[15] = 16'd9;
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clock);
      #1;
      if (accum_rd_addr == 4'd8) hit = 1'b1;
    end
    check("abort reached addr 8", int'(hit), 1);
    check("abort partial left_rho",   int'(left_rho),   1);
    check("abort partial left_theta", int'(left_theta), 1);
    #2 reset = 1'b0;
    #1;
    check("abort addr",        int'(accum_rd_addr), 0);
    check("abort busy",        int'(busy),          0);
    check("abort out_valid",   int'(out_valid),     0);
    check("abort left_rho",    int'(left_rho),      0);
    check("abort left_theta",  int'(left_theta),    0);
    check("abort right_rho",   int'(right_rho),     0);
    check("abort right_theta", int'(right_theta),   0);
    check("abort valids",      int'({left_valid, right_valid}), 0);
    @(negedge clock) reset = 1'b1;
    watch_idle("abort", 20);
    load_vec(tbl[0]);
    start_and_wait(tbl[0], "after-abort");
    handshake("after-abort");

    // start together with the acknowledging out_ready
    load_vec(tbl[1]);
    start_and_wait(tbl[1], "b2b");
    @(negedge clock);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    out_ready = 1'b0;
    check("b2b busy after ack",      int'(busy),      0);
    check("b2b out_valid after ack", int'(out_valid), 0);
    watch_idle("b2b", 20);
    load_vec(tbl[2]);
    start_and_wait(tbl[2], "b2b-next");
    handshake("b2b-next");

    check("scoreboard drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
